// File: rtl/xmod_pkg.sv
// Shared definitions for the iterative X mod (2^K - C) residue unit.
//   state_t      : controller states
//   FOLD_CNT_W   : width of the optional fold-step counter
//   prod_width() : width of hi * C, where hi is (W-K) bits and C fits in K bits
package xmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FOLD_CNT_W = 8;

  // hi has W-K bits and C has at most K bits, so the product never needs more than W bits.
  function automatic int unsigned prod_width(input int unsigned w, input int unsigned k);
    return (w - k) + k;
  endfunction

endpackage

// File: rtl/xmod_fold_step.sv
// Combinational fold step for M = 2^K - C.
//   acc      in  W : current accumulator
//   acc_next out W : acc[K-1:0] + acc[W-1:K] * C   (2^K == C mod M)
//   hi_zero  out 1 : acc[W-1:K] == 0, i.e. acc < 2^K
//   r_corr   out K : low K bits with one conditional subtract of M
module xmod_fold_step
  import xmod_pkg::*;
#(
  parameter int unsigned W = 100,
  parameter int unsigned K = 8,
  parameter int unsigned C = 15
) (
  input  logic [W-1:0] acc,
  output logic [W-1:0] acc_next,
  output logic         hi_zero,
  output logic [K-1:0] r_corr
);

  localparam int unsigned HI_W   = W - K;
  localparam int unsigned PROD_W = prod_width(W, K);
  localparam logic [K-1:0] M     = K'((64'd1 << K) - 64'(C));

  logic [HI_W-1:0]   hi;
  logic [K-1:0]      lo;
  logic [PROD_W-1:0] prod;

  assign hi      = acc[W-1:K];
  assign lo      = acc[K-1:0];
  assign hi_zero = (hi == '0);

  // The sum is strictly smaller than acc whenever hi != 0, so W bits always suffice.
  assign prod     = PROD_W'(hi) * PROD_W'(C);
  assign acc_next = W'(lo) + W'(prod);

  // Once hi == 0 we have lo < 2^K < 2M, so a single subtract finishes the reduction.
  assign r_corr = (lo >= M) ? (lo - M) : lo;

endmodule

// File: rtl/x_mod_fold_seq.sv
// Sequential residue unit: out_r = in_x mod (2^K - C) by iterative folding.
// Optional feature macro: XMOD_FOLD_CNT_EN adds the out_folds port and fold counter.
//   clk        in  1  clock, rising edge
//   rst        in  1  synchronous active-high reset
//   in_valid   in  1  operand present
//   in_ready   out 1  unit idle, can accept an operand
//   in_x       in  W  operand, unsigned
//   out_valid  out 1  result present
//   out_ready  in  1  consumer accepts result
//   out_r      out K  residue, 0..M-1
//   out_folds  out 8  fold steps used (XMOD_FOLD_CNT_EN only)
module x_mod_fold_seq
  import xmod_pkg::*;
#(
  parameter int unsigned W = 100,
  parameter int unsigned K = 8,
  parameter int unsigned C = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [K-1:0]          out_r
`ifdef XMOD_FOLD_CNT_EN
  ,
  output logic [FOLD_CNT_W-1:0] out_folds
`endif
);

  // Reject configurations where the fold does not strictly shrink or the result
  // would not fit: C must be nonzero and below 2^(K-1), and W must exceed K.
  generate
    if (C == 0 || C >= (32'd1 << (K - 1)) || W <= K || prod_width(W, K) != W) begin : g_bad_cfg
      $error("x_mod_fold_seq: illegal parameters W=%0d K=%0d C=%0d", W, K, C);
    end
  endgenerate

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_next;
  logic           hi_zero;
  logic [K-1:0]   r_corr;
  logic           accept_c;
  logic           fold_c;
  logic           finish_c;

  xmod_fold_step #(
    .W(W),
    .K(K),
    .C(C)
  ) u_fold_step (
    .acc     (acc),
    .acc_next(acc_next),
    .hi_zero (hi_zero),
    .r_corr  (r_corr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and step-control decode.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    fold_c     = 1'b0;
    finish_c   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = FOLD;
        end
      end
      FOLD: begin
        if (hi_zero) begin
          finish_c   = 1'b1;
          state_next = DONE;
        end else begin
          fold_c = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, result and handshake registers; handshake flags mirror the next state
  // so they stay pure functions of registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= (state_next == DONE);
      in_ready  <= (state_next == IDLE);
      if (accept_c) begin
        acc <= in_x;
      end else if (fold_c) begin
        acc <= acc_next;
      end
      if (finish_c) begin
        out_r <= r_corr;
      end
    end
  end

`ifdef XMOD_FOLD_CNT_EN
  logic [FOLD_CNT_W-1:0] fold_cnt;

  // Fold-step counter: cleared on accept, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      fold_cnt <= '0;
    end else if (accept_c) begin
      fold_cnt <= '0;
    end else if (fold_c && (fold_cnt != '1)) begin
      fold_cnt <= fold_cnt + FOLD_CNT_W'(1);
    end
  end

  assign out_folds = fold_cnt;
`endif

endmodule

// File: tb/tb_x_mod_fold_seq.sv
// Self-checking bench for x_mod_fold_seq: a 100-bit/mod-241 instance and a
// 64-bit/mod-65521 instance, with a result scoreboard per instance.
module tb_x_mod_fold_seq;

  logic clk = 1'b0;
  logic rst;

  logic         a_in_valid;
  logic         a_in_ready;
  logic [99:0]  a_in_x;
  logic         a_out_valid;
  logic         a_out_ready;
  logic [7:0]   a_out_r;

  logic         b_in_valid;
  logic         b_in_ready;
  logic [63:0]  b_in_x;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [15:0]  b_out_r;

`ifdef XMOD_FOLD_CNT_EN
  logic [7:0]   a_folds;
  logic [7:0]   b_folds;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]  q1[$];
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  x_mod_fold_seq #(.W(100), .K(8), .C(15)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_x     (a_in_x),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_r    (a_out_r)
`ifdef XMOD_FOLD_CNT_EN
    ,
    .out_folds(a_folds)
`endif
  );

  x_mod_fold_seq #(.W(64), .K(16), .C(15)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_x     (b_in_x),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_r    (b_out_r)
`ifdef XMOD_FOLD_CNT_EN
    ,
    .out_folds(b_folds)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on each output handshake (out_ready is settled by the falling edge).
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      chk("sb_a_nonempty", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) chk("sb_a_r", 64'(a_out_r), 64'(q1.pop_front()));
    end
    if (!rst && b_out_valid && b_out_ready) begin
      chk("sb_b_nonempty", 64'(q2.size() > 0), 64'd1);
      if (q2.size() > 0) chk("sb_b_r", 64'(b_out_r), 64'(q2.pop_front()));
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic send_a(input logic [99:0] x, input logic [7:0] er, input bit rnd_rdy);
    int n;
    n = 0;
    while (!a_in_ready && n < 2000) begin
      if (rnd_rdy) a_out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("a_in_ready_wait", 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b1;
    a_in_x     = x;
    q1.push_back(er);
    if (rnd_rdy) a_out_ready = 1'($urandom_range(0, 1));
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] x, input logic [15:0] er, input bit rnd_rdy);
    int n;
    n = 0;
    while (!b_in_ready && n < 2000) begin
      if (rnd_rdy) b_out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("b_in_ready_wait", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b1;
    b_in_x     = x;
    q2.push_back(er);
    if (rnd_rdy) b_out_ready = 1'($urandom_range(0, 1));
    step();
    b_in_valid = 1'b0;
  endtask

  // Directed operand with out_ready high: checks latency (F+2) and the result.
  task automatic run_a(input string tag, input logic [99:0] x, input logic [7:0] er, input int efolds);
    int n;
    send_a(x, er, 1'b0);
    n = 0;
    while (!a_out_valid && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n + 1), 64'(efolds + 2));
    chk({tag, "_r"}, 64'(a_out_r), 64'(er));
    chk({tag, "_in_ready_busy"}, 64'(a_in_ready), 64'd0);
`ifdef XMOD_FOLD_CNT_EN
    chk({tag, "_folds"}, 64'(a_folds), 64'(efolds));
`endif
    step();
    chk({tag, "_in_ready_after"}, 64'(a_in_ready), 64'd1);
  endtask

  initial begin
    logic [127:0] t;
    logic [99:0]  x;
    logic [63:0]  y;
    int           n;

    rst         = 1'b1;
    a_in_valid  = 1'b0;
    a_in_x      = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_x      = '0;
    b_out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_out_r", 64'(a_out_r), 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
`ifdef XMOD_FOLD_CNT_EN
    chk("rst_a_folds", 64'(a_folds), 64'd0);
`endif

    run_a("x256", 100'd256, 8'd15, 1);
    run_a("x65535", 100'd65535, 8'd224, 3);
    run_a("x241", 100'd241, 8'd0, 0);
    run_a("x240", 100'd240, 8'd240, 0);
    run_a("x0", 100'd0, 8'd0, 0);

    // Backpressure: result held, new operands refused.
    a_out_ready = 1'b0;
    send_a(100'd65535, 8'd224, 1'b0);
    n = 0;
    while (!a_out_valid && n < 200) begin
      step();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1;
      a_in_x     = 100'd12345;
      chk("bp_out_valid", 64'(a_out_valid), 64'd1);
      chk("bp_out_r", 64'(a_out_r), 64'd224);
      chk("bp_in_ready", 64'(a_in_ready), 64'd0);
      step();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 64'(a_in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(a_out_valid), 64'd0);
    run_a("after_bp", 100'd256, 8'd15, 1);

    // Reset mid-fold on the all-ones operand discards it.
    a_in_valid = 1'b1;
    a_in_x     = '1;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    step();
    chk("midfold_busy", 64'(a_in_ready), 64'd0);
    chk("midfold_no_valid", 64'(a_out_valid), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 64'(a_in_ready), 64'd1);
    chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
    chk("midrst_out_r", 64'(a_out_r), 64'd0);
`ifdef XMOD_FOLD_CNT_EN
    chk("midrst_folds", 64'(a_folds), 64'd0);
`endif
    run_a("post_rst", 100'd65535, 8'd224, 3);

    // Random sweep, M = 241, random out_ready.
    for (int i = 0; i < 500; i++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      x = t[99:0] >> $urandom_range(0, 99);
      send_a(x, 8'(x % 100'd241), 1'b1);
    end
    a_out_ready = 1'b1;
    n = 0;
    while (q1.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk("sweep_a_drained", 64'(q1.size()), 64'd0);

    // Second configuration: W=64, K=16, C=15 (M = 65521).
    send_b(64'd65521, 16'd0, 1'b0);
    send_b(64'd65535, 16'd14, 1'b0);
    send_b(64'hFFFF_FFFF_FFFF_FFFF, 16'(64'hFFFF_FFFF_FFFF_FFFF % 64'd65521), 1'b0);
    for (int i = 0; i < 500; i++) begin
      y = {$urandom(), $urandom()};
      y = y >> $urandom_range(0, 63);
      send_b(y, 16'(y % 64'd65521), 1'b1);
    end
    b_out_ready = 1'b1;
    n = 0;
    while (q2.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk("sweep_b_drained", 64'(q2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
